// File: rtl/instr_decoder_pkg.sv
// instr_decoder_pkg
// Shared encodings for the E-stage instruction decoder: MIPS opcode and
// funct field values, plus the Tnew codes (cycles until a result can be
// forwarded).
package instr_decoder_pkg;

  // Opcode field, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  // Funct field, instruction bits [5:0]
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_CLZ  = 6'b100000;

  // Tnew codes
  localparam logic [1:0] T_PC  = 2'd0;
  localparam logic [1:0] T_ALU = 2'd1;
  localparam logic [1:0] T_DM  = 2'd2;

endpackage

// File: rtl/instr_decoder_tnew_tracker.sv
// tnew_tracker
// Registered Tnew copy for the hazard unit. It loads a fresh Tnew on
// request and otherwise counts down once per cycle, saturating at zero.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears tnew_q
//   load   in   capture tnew this cycle (overrides the decrement)
//   tnew   in   [1:0] decoded Tnew to capture
//   tnew_q out  [1:0] registered, self-decrementing Tnew
module tnew_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] tnew,
  output logic [1:0] tnew_q
);

  logic [1:0] r_tnew;

  // reset beats load; load beats the decrement; zero holds at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tnew <= '0;
    end else if (load) begin
      r_tnew <= tnew;
    end else if (r_tnew != '0) begin
      r_tnew <= r_tnew - 2'd1;
    end
  end

  assign tnew_q = r_tnew;

endmodule

// File: rtl/instr_decoder.sv
// instr_decoder
// Decode-side control block for the 5-stage MIPS pipeline. Turns the
// opcode/funct fields into one-hot instruction flags and a Tnew value,
// and keeps a registered, self-decrementing Tnew copy for stall/forward.
//
// Build option: define CLZ_EN to decode clz (SPECIAL2/CLZ). Without it
// the clz flag is tied low and that encoding is treated as unknown.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; clears tnew_q
//   op      in   [5:0] instruction bits [31:26]
//   func    in   [5:0] instruction bits [5:0]
//   load    in   capture decoded tnew into tnew_q this cycle
//   addu, subu, ori, lui, lw, jal, clz  out  one-hot instruction flags
//   tnew    out  [1:0] combinational Tnew of op/func
//   tnew_q  out  [1:0] registered Tnew, decrementing each cycle
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       load,
  output logic       addu,
  output logic       subu,
  output logic       ori,
  output logic       lui,
  output logic       lw,
  output logic       jal,
  output logic       clz,
  output logic [1:0] tnew,
  output logic [1:0] tnew_q
);

  logic w_addu, w_subu, w_ori, w_lui, w_lw, w_jal, w_clz;
  logic [1:0] w_tnew;

  always_comb begin
    w_addu = (op == OP_RTYPE) && (func == FN_ADDU);
    w_subu = (op == OP_RTYPE) && (func == FN_SUBU);
    w_ori  = (op == OP_ORI);
    w_lui  = (op == OP_LUI);
    w_lw   = (op == OP_LW);
    w_jal  = (op == OP_JAL);
`ifdef CLZ_EN
    w_clz  = (op == OP_SPECIAL2) && (func == FN_CLZ);
`else
    w_clz  = 1'b0;
`endif
  end

  always_comb begin
    w_tnew = T_PC;
    if (w_addu || w_subu || w_ori || w_lui || w_clz) begin
      w_tnew = T_ALU;
    end else if (w_lw) begin
      w_tnew = T_DM;
    end
  end

  assign addu = w_addu;
  assign subu = w_subu;
  assign ori  = w_ori;
  assign lui  = w_lui;
  assign lw   = w_lw;
  assign jal  = w_jal;
  assign clz  = w_clz;
  assign tnew = w_tnew;

  tnew_tracker u_tnew_tracker (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .tnew   (w_tnew),
    .tnew_q (tnew_q)
  );

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder
// Directed bench for instr_decoder. Inputs change 1 time unit after the
// rising edge; outputs are sampled before the next edge. Expectations
// for the CLZ encoding follow the CLZ_EN build option.
module tb_instr_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       load = 1'b0;
  logic       addu, subu, ori, lui, lw, jal, clz;
  logic [1:0] tnew, tnew_q;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .func   (func),
    .load   (load),
    .addu   (addu),
    .subu   (subu),
    .ori    (ori),
    .lui    (lui),
    .lw     (lw),
    .jal    (jal),
    .clz    (clz),
    .tnew   (tnew),
    .tnew_q (tnew_q)
  );

  // {addu,subu,ori,lui,lw,jal,clz}
  function automatic logic [6:0] flags_now();
    return {addu, subu, ori, lui, lw, jal, clz};
  endfunction

  // Independent reference model written from the encoding table
  function automatic logic [6:0] ref_flags(input logic [5:0] o, input logic [5:0] f);
    logic [6:0] r;
    r = 7'b0;
    if (o == 6'd0 && f == 6'd33) r[6] = 1'b1;
    if (o == 6'd0 && f == 6'd35) r[5] = 1'b1;
    if (o == 6'd13) r[4] = 1'b1;
    if (o == 6'd15) r[3] = 1'b1;
    if (o == 6'd35) r[2] = 1'b1;
    if (o == 6'd3)  r[1] = 1'b1;
`ifdef CLZ_EN
    if (o == 6'd28 && f == 6'd32) r[0] = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [1:0] ref_tnew(input logic [6:0] fl);
    if (fl[6] | fl[5] | fl[4] | fl[3] | fl[0]) return 2'd1;
    if (fl[2]) return 2'd2;
    return 2'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string name, input logic [1:0] exp);
    vectors++;
    if (tnew_q !== exp) begin
      miscompares++;
      $display("FAIL %s: tnew_q got %0d expected %0d", name, tnew_q, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (tnew_q !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: tnew_q got %0d expected 0", tnew_q);
    end
  endtask

  task automatic test_decode_directed();
    logic [5:0] ops   [7] = '{6'b000000, 6'b000000, 6'b100011, 6'b000011, 6'b000000, 6'b001101, 6'b001111};
    logic [5:0] funcs [7] = '{6'b100001, 6'b100011, 6'b010101, 6'b000000, 6'b000000, 6'b111111, 6'b000001};
    logic [6:0] eflag [7] = '{7'b1000000, 7'b0100000, 7'b0000100, 7'b0000010, 7'b0000000, 7'b0010000, 7'b0001000};
    logic [1:0] etnew [7] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 7; i++) begin
      op = ops[i];
      func = funcs[i];
      #1;
      vectors++;
      if (flags_now() !== eflag[i] || tnew !== etnew[i]) begin
        miscompares++;
        $display("FAIL decode[%0d]: flags=%b tnew=%0d expected flags=%b tnew=%0d",
                 i, flags_now(), tnew, eflag[i], etnew[i]);
      end
    end
  endtask

  task automatic test_clz();
    logic [6:0] ef;
    logic [1:0] et;
`ifdef CLZ_EN
    ef = 7'b0000001;
    et = 2'd1;
`else
    ef = 7'b0000000;
    et = 2'd0;
`endif
    op = 6'b011100;
    func = 6'b100000;
    #1;
    vectors++;
    if (flags_now() !== ef || tnew !== et) begin
      miscompares++;
      $display("FAIL clz: flags=%b tnew=%0d expected flags=%b tnew=%0d", flags_now(), tnew, ef, et);
    end
  endtask

  task automatic test_countdown();
    op = 6'b100011;
    func = 6'b000000;
    load = 1'b1;
    step();
    load = 1'b0;
    check_q("countdown_2", 2'd2);
    step();
    check_q("countdown_1", 2'd1);
    step();
    check_q("countdown_0", 2'd0);
    step();
    check_q("countdown_sat0", 2'd0);
    step();
    check_q("countdown_sat0b", 2'd0);
  endtask

  task automatic test_reset_interaction();
    // reset mid-countdown
    op = 6'b100011;
    load = 1'b1;
    step();
    load = 1'b0;
    check_q("pre_reset_load", 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_q("reset_mid_countdown", 2'd0);
    step();
    check_q("after_reset_holds", 2'd0);
    // reset wins over load
    load = 1'b1;
    step();
    check_q("reload_lw", 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 1'b0;
    check_q("reset_beats_load", 2'd0);
  endtask

  task automatic test_back_to_back();
    op = 6'b001101;
    func = 6'b000000;
    load = 1'b1;
    step();
    check_q("load_ori", 2'd1);
    op = 6'b100011;
    step();
    check_q("load_lw_after_ori", 2'd2);
    // load while nonzero: overwrite, no decrement this cycle
    step();
    check_q("load_lw_over_lw", 2'd2);
    op = 6'b000011;
    step();
    check_q("load_jal_over_lw", 2'd0);
    load = 1'b0;
  endtask

  task automatic test_sweep();
    logic [6:0] ef;
    logic [6:0] got;
    int hits;
    hits = 0;
    for (int o = 0; o < 64; o++) begin
      for (int f = 0; f < 64; f++) begin
        op = 6'(o);
        func = 6'(f);
        #1;
        got = flags_now();
        ef = ref_flags(op, func);
        if (got != 7'b0) hits++;
        vectors++;
        if (got !== ef || tnew !== ref_tnew(ef) || $countones(got) > 1) begin
          miscompares++;
          $display("FAIL sweep op=%b func=%b: flags=%b tnew=%0d expected flags=%b tnew=%0d",
                   op, func, got, tnew, ef, ref_tnew(ef));
        end
      end
    end
    // addu, subu, clz single funct each; ori/lui/lw/jal any of 64 functs
`ifdef CLZ_EN
    vectors++;
    if (hits != 259) begin
      miscompares++;
      $display("FAIL sweep_hits: got %0d expected 259", hits);
    end
`else
    vectors++;
    if (hits != 258) begin
      miscompares++;
      $display("FAIL sweep_hits: got %0d expected 258", hits);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_clz();
    test_countdown();
    test_reset_interaction();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
